aes128_key_expand_seq: RTL and testbench

Sequential AES-128 key schedule sitting directly upstream of the combinational AES-128 decryption datapath. It expands a 128-bit cipher key into round keys 0..10, one round per clock, and holds them in an internal key store. The decryption datapath reads the keys in reverse order (10 down to 0) through a registered read port, which removes the unrolled 10-stage key-expansion logic from the decryption cone.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes128_key_expand_seq_if.sv | 31 +++
 rtl/aes_sub_word.sv | 33 +++
 rtl/aes128_key_expand_seq.sv | 100 ++++++++++
 tb/tb_aes128_key_expand_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the sequential key schedule: round count,
// rcon constants, block/word types and the key-schedule state encoding.
package aes_pkg;

    localparam int unsigned NR         = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;
    localparam logic [7:0]  XTIME_POLY = 8'h1b;

    // Bit 0 is the MSB of byte 0, matching the cipher_key/en_msg buses.
    typedef logic [0:127] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_t;

endpackage

// File: rtl/aes128_key_expand_seq_if.sv
// Load/status/read-port bundle between the key schedule and the
// decryption datapath that consumes its round keys.
interface aes128_key_expand_seq_if;
    import aes_pkg::*;

    aes_block_t  key_in;
    logic        key_load;
    logic        busy;
    logic        key_ready;
    logic [3:0]  rd_round;
    aes_block_t  rd_key;

    modport master (
        output key_in,
        output key_load,
        output rd_round,
        input  busy,
        input  key_ready,
        input  rd_key
    );

    modport slave (
        input  key_in,
        input  key_load,
        input  rd_round,
        output busy,
        output key_ready,
        output rd_key
    );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, using the
// same table as the encryption sub_byte stage.
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word_in,
    output aes_word_t word_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
    end

endmodule

// File: rtl/aes128_key_expand_seq.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry
// resettable key store, read back through a registered port.
module aes128_key_expand_seq #(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic                        clk,
    input  logic                        rst,
    aes128_key_expand_seq_if.slave      ks
);
    import aes_pkg::*;

    ks_state_t   state, state_nxt;
    logic [3:0]  cnt;
    logic [7:0]  rcon;
    aes_block_t  w;
    aes_block_t  w_nxt;
    aes_block_t  store [NR+1];
    aes_block_t  rd_key_q;
    logic        busy_c, ready_c, load_acc;

    aes_word_t   w3_rot, sub_out, temp;
    aes_word_t   n0, n1, n2, n3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // RotWord on w3: bytes {13,14,15,12} of the working block.
    assign w3_rot = {w[104:127], w[96:103]};

    aes_sub_word u_sub_word (
        .word_in  (w3_rot),
        .word_out (sub_out)
    );

    assign temp  = sub_out ^ {rcon, 24'h000000};
    assign n0    = w[0:31]   ^ temp;
    assign n1    = w[32:63]  ^ n0;
    assign n2    = w[64:95]  ^ n1;
    assign n3    = w[96:127] ^ n2;
    assign w_nxt = {n0, n1, n2, n3};

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        ready_c   = 1'b0;
        load_acc  = 1'b0;
        case (state)
            IDLE: begin
                load_acc = ks.key_load;
                if (ks.key_load) state_nxt = EXPAND;
            end
            EXPAND: begin
                busy_c = 1'b1;
                if (cnt == 4'(NR)) state_nxt = READY;
            end
            READY: begin
                ready_c  = 1'b1;
                load_acc = ks.key_load;
                if (ks.key_load) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rcon     <= RCON_INIT;
            w        <= '0;
            rd_key_q <= '0;
            for (int unsigned i = 0; i <= NR; i++) store[i] <= '0;
        end else begin
            if (load_acc) begin
                store[0] <= ks.key_in;
                w        <= ks.key_in;
                rcon     <= RCON_INIT;
                cnt      <= 4'd1;
            end else if (state == EXPAND) begin
                store[cnt] <= w_nxt;
                w          <= w_nxt;
                rcon       <= xtime(rcon);
                cnt        <= cnt + 4'd1;
            end
            // Reads see the store before this edge's write: no bypass.
            if (ks.rd_round <= 4'(NR)) rd_key_q <= store[ks.rd_round];
            else                       rd_key_q <= '0;
        end
    end

    assign ks.busy      = busy_c;
    assign ks.key_ready = ready_c;
    assign ks.rd_key    = rd_key_q;

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Scoreboard bench for aes128_key_expand_seq against a FIPS-197 key-schedule
// model built from GF(2^8) arithmetic.
module tb_aes128_key_expand_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_key_expand_seq_if ks_if ();

    aes128_key_expand_seq dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    int total = 0;
    int bad   = 0;

    logic         rd_req = 1'b0;
    logic [127:0] exp_q [$];
    int           rnd_q [$];

    logic [7:0]   sbox_tab [256];
    logic [127:0] model_rk [11];
    logic [127:0] old_rk   [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] wd [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [127:0] e;
        int           r;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard: read with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    r = rnd_q.pop_front();
                    check($sformatf("rd_key[%0d]", r), ks_if.rd_key, e);
                end
            end else begin
                #1;
            end
            if (ks_if.busy && ks_if.key_ready) begin
                bad++;
                $display("FAIL busy_and_ready: got 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic read_at(input int r, input logic [127:0] e);
        ks_if.rd_round = 4'(r);
        rd_req = 1'b1;
        exp_q.push_back(e);
        rnd_q.push_back(r);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        int r;
        for (int i = 0; i < 11; i++) read_at(i, model_rk[i]);
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 15);
            read_at(r, (r <= 10) ? model_rk[r] : 128'h0);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        compute_model(key);
        ks_if.key_in   = key;
        ks_if.key_load = 1'b1;
        @(negedge clk);
        ks_if.key_load = 1'b0;
        ks_if.key_in   = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_load", 128'(ks_if.busy), 128'h1);
        check("ready_after_load", 128'(ks_if.key_ready), 128'h0);
    endtask

    task automatic wait_expand(input int start_k, input bit repulse);
        for (int k = start_k; k <= 10; k++) begin
            if (repulse && (k == 3 || k == 7)) begin
                ks_if.key_load = 1'b1;
                ks_if.key_in   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            ks_if.key_load = 1'b0;
            check($sformatf("busy_e0+%0d", k), 128'(ks_if.busy), 128'(k < 10));
            check($sformatf("ready_e0+%0d", k), 128'(ks_if.key_ready), 128'(k == 10));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] ka;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

        rst = 1'b1;
        ks_if.key_in   = '0;
        ks_if.key_load = 1'b0;
        ks_if.rd_round = 4'd0;
        #1;
        check("reset_busy", 128'(ks_if.busy), 128'h0);
        check("reset_ready", 128'(ks_if.key_ready), 128'h0);
        check("reset_rd_key", ks_if.rd_key, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_at(3, 128'h0);

        // FIPS-197 appendix A.1 key
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_expand(1, 1'b0);
        read_at(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_at(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_all();

        // all-zero key
        load_key(128'h0);
        wait_expand(1, 1'b0);
        read_at(1, 128'h62636363626363636263636362636363);
        read_at(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_at(0, 128'h0);

        // key_load re-pulsed during expansion must be ignored
        load_key({$urandom, $urandom, $urandom, $urandom});
        wait_expand(1, 1'b1);
        read_all();

        // reload from READY: old keys visible, no write-to-read bypass
        old_rk = model_rk;
        load_key({$urandom, $urandom, $urandom, $urandom});
        read_at(1, old_rk[1]);
        read_at(0, model_rk[0]);
        wait_expand(3, 1'b0);
        read_at(10, model_rk[10]);
        read_at(15, 128'h0);

        // asynchronous reset in the middle of an expansion
        ks_if.rd_round = 4'd0;
        ka = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        load_key(ka);
        repeat (5) @(negedge clk);
        check("rd_key_pre_reset", ks_if.rd_key, ka);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 128'(ks_if.busy), 128'h0);
        check("midrst_ready", 128'(ks_if.key_ready), 128'h0);
        check("midrst_rd_key", ks_if.rd_key, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        read_at(5, 128'h0);
        read_at(0, 128'h0);
        load_key({$urandom, $urandom, $urandom, $urandom});
        wait_expand(1, 1'b0);
        read_all();

        // random keys
        for (int n = 0; n < 4; n++) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            wait_expand(1, 1'b0);
            read_all();
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
